// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier driving the datapath ALU (one ADD per step).
// Ports: CLK/RST, req valid/ready/a/b, resp valid/ready/prod, alu portA/portB/aluOp/outPort.
package alu_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_mult_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_prod,
  output logic [31:0] alu_portA,
  output logic [31:0] alu_portB,
  output aluop_t      alu_aluOp,
  input  logic [31:0] alu_outPort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  cnt;

  logic        iter;
  logic        last;
  logic [31:0] acc_nxt;

  assign iter = (state == ITER);

  // ALU sees zeros whenever no step is in flight
  assign alu_portA = iter ? acc   : '0;
  assign alu_portB = iter ? mcand : '0;
  assign alu_aluOp = ALU_ADD;

  assign acc_nxt = mplier[0] ? alu_outPort : acc;

  // Early exit looks at the multiplier after this step's shift
  assign last = (cnt == 5'd31) ||
                (EARLY_EXIT && (mplier[31:1] == 31'd0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc       <= '0;
            mcand     <= req_a;
            mplier    <= req_b;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= ITER;
          end
        end
        ITER: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last) begin
            resp_prod  <= acc_nxt;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq against a behavioural product model.
// Covers both EARLY_EXIT settings, backpressure, mid-op reset, random ops.
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        sel;
  logic        req_valid;
  logic        resp_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        rr1, rv1, rr0, rv0;
  logic [31:0] rp1, pa1, pb1, ao1;
  logic [31:0] rp0, pa0, pb0, ao0;
  aluop_t      op1, op0;

  logic        rr, rv;
  logic [31:0] rp, pa, pb;
  aluop_t      op;

  int errors;
  int checks;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ao1 = pa1 + pb1;
  assign ao0 = pa0 + pb0;

  alu_mult_seq #(.EARLY_EXIT(1'b1)) u_ee1 (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid & ~sel),
    .req_ready   (rr1),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (rv1),
    .resp_ready  (resp_ready & ~sel),
    .resp_prod   (rp1),
    .alu_portA   (pa1),
    .alu_portB   (pb1),
    .alu_aluOp   (op1),
    .alu_outPort (ao1)
  );

  alu_mult_seq #(.EARLY_EXIT(1'b0)) u_ee0 (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid & sel),
    .req_ready   (rr0),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (rv0),
    .resp_ready  (resp_ready & sel),
    .resp_prod   (rp0),
    .alu_portA   (pa0),
    .alu_portB   (pb0),
    .alu_aluOp   (op0),
    .alu_outPort (ao0)
  );

  assign rr = sel ? rr0 : rr1;
  assign rv = sel ? rv0 : rv1;
  assign rp = sel ? rp0 : rp1;
  assign pa = sel ? pa0 : pa1;
  assign pb = sel ? pb0 : pb1;
  assign op = sel ? op0 : op1;

  function automatic int ref_iters(input logic [31:0] b, input bit ee);
    int h;
    if (!ee) return 32;
    h = 0;
    for (int i = 0; i < 32; i++)
      if (b[i]) h = i + 1;
    return (h == 0) ? 1 : h;
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold);
    logic [31:0] exp_p;
    int          exp_n;
    int          n;
    bit          bad;
    exp_p = a * b;
    exp_n = ref_iters(b, !sel);
    n = 0;
    while (rr !== 1'b1 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (rr !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b want 1", rr);
    end
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    checks++;
    if (rr !== 1'b0) begin
      errors++;
      $display("FAIL accept: req_ready=%b want 0", rr);
    end
    n = 0; bad = 0;
    while (rv !== 1'b1 && n < 40) begin
      if (op !== ALU_ADD || rr !== 1'b0) bad = 1;
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (rv !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%b want 1", rv);
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL latency a=%h b=%h: iter=%0d want %0d", a, b, n, exp_n);
    end
    checks++;
    if (rp !== exp_p) begin
      errors++;
      $display("FAIL prod a=%h b=%h: got %h want %h", a, b, rp, exp_p);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL iter_drive: aluOp/req_ready wrong in ITER, got %0d want %0d", bad, 0);
    end
    checks++;
    if (pa !== 32'd0 || pb !== 32'd0) begin
      errors++;
      $display("FAIL done_alu: portA=%h portB=%h want 0", pa, pb);
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        if (rv !== 1'b1 || rp !== exp_p || rr !== 1'b0) bad = 1;
      end
      req_valid = 1'b0;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL backpressure: valid=%b prod=%h ready=%b want 1 %h 0",
                 rv, rp, rr, exp_p);
      end
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    checks++;
    if (rv !== 1'b0 || rr !== 1'b1) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b want 0 1", rv, rr);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    checks++;
    if (rr1 !== 1'b1 || rv1 !== 1'b0 || rp1 !== 32'd0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b prod=%h want 1 0 0", rr1, rv1, rp1);
    end
    checks++;
    if (pa1 !== 32'd0 || pb1 !== 32'd0 || op1 !== ALU_ADD) begin
      errors++;
      $display("FAIL reset_alu: A=%h B=%h op=%0d want 0 0 %0d", pa1, pb1, op1, ALU_ADD);
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    run_op(32'd7, 32'd6, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(32'hFFFFFFFD, 32'd5, 0);
    run_op(32'h12345678, 32'd0, 0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_op(32'd11, 32'd13, 10);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_op(32'd100, 32'd3, 0);
    run_op(32'd9, 32'h80000000, 0);
  endtask

  task automatic test_midop_reset();
    bit stale;
    sel = 1'b0;
    req_a = 32'h1234; req_b = 32'h8000; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if (rv1 !== 1'b0 || rr1 !== 1'b1 || pa1 !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset: valid=%b ready=%b A=%h want 0 1 0", rv1, rr1, pa1);
    end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (rv1 !== 1'b0 || rv0 !== 1'b0) stale = 1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL stale_resp: got %0d want %0d", stale, 0);
    end
  endtask

  task automatic test_no_early_exit();
    sel = 1'b1;
    run_op(32'd3, 32'd1, 0);
    run_op(32'hDEADBEEF, 32'h00000000, 2);
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      sel = (i % 5 == 4);
      run_op(a, b, $urandom_range(0, 3));
    end
    sel = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel = 1'b0;
    RST = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_midop_reset();
    test_no_early_exit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
